// File: rtl/mem_prog_ctrl.sv
// Write-verify programming controller for one memristor cell: applies coarse or fine
// SET/RESET pulses until the read-back conductance is within TOL of the target.
module mem_prog_ctrl #(
    parameter int unsigned M          = 15,
    parameter int unsigned N          = 15,
    parameter int unsigned V_HI       = 32,
    parameter int unsigned V_LO       = 8,
    parameter int unsigned COARSE_THR = 64,
    parameter int unsigned TOL        = 4,
    parameter int unsigned MAX_PULSES = 255,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic                i_init,
    input  logic                i_abort,
    input  logic signed [N:0]   i_target_g,
    input  logic signed [N:0]   i_g,
    output logic signed [M:0]   o_vin,
    output logic                o_v_valid,
    output logic                o_mem_reset,
    output logic                o_busy,
    output logic                o_done,
    output logic [1:0]          o_status,
    output logic [7:0]          o_pulse_cnt
);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StCompare,
        StPulse,
        StSettle,
        StDone
    } state_e;

    localparam logic [1:0]        StatOk      = 2'b00;
    localparam logic [1:0]        StatTimeout = 2'b01;
    localparam logic [1:0]        StatAbort   = 2'b10;

    localparam logic [N+1:0]      TOL_W       = (N+2)'(TOL);
    localparam logic [N+1:0]      THR_W       = (N+2)'(COARSE_THR);
    localparam logic signed [M:0] V_HI_W      = (M+1)'(V_HI);
    localparam logic signed [M:0] V_LO_W      = (M+1)'(V_LO);
    localparam logic [7:0]        MAX_PULSE_W = 8'(MAX_PULSES);
    localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYC - 1);

    state_e             r_state;
    state_e             w_state_next;
    logic signed [N:0]  r_target;
    logic [3:0]         r_settle_cnt;
    logic [3:0]         w_settle_next;
    logic [1:0]         r_status;
    logic [1:0]         w_status_next;
    logic [7:0]         r_pulse_cnt;
    logic [7:0]         w_pcnt_next;
    logic signed [M:0]  r_vin;
    logic               r_v_valid;
    logic               r_mem_reset;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_abort;
    logic signed [N+1:0] w_tgt_x;
    logic signed [N+1:0] w_g_x;
    logic signed [N+1:0] w_err;
    logic [N+1:0]       w_err_abs;
    logic               w_in_tol;
    logic               w_budget_out;
    logic signed [M:0]  w_mag;
    logic signed [M:0]  w_pulse_v;

    // Error is widened by one bit so target - G can never overflow.
    assign w_tgt_x      = {r_target[N], r_target};
    assign w_g_x        = {i_g[N], i_g};
    assign w_err        = w_tgt_x - w_g_x;
    assign w_err_abs    = w_err[N+1] ? (-w_err) : w_err;
    assign w_in_tol     = (w_err_abs <= TOL_W);
    assign w_budget_out = (r_pulse_cnt == MAX_PULSE_W);
    assign w_mag        = (w_err_abs > THR_W) ? V_HI_W : V_LO_W;
    assign w_pulse_v    = w_err[N+1] ? (-w_mag) : w_mag;

    assign w_accept = (r_state == StIdle) && i_start;
    assign w_abort  = i_abort && (r_state inside {StInit, StCompare, StPulse, StSettle});

    always_comb begin
        w_state_next  = r_state;
        w_status_next = r_status;
        w_pcnt_next   = r_pulse_cnt;
        w_settle_next = '0;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next  = i_init ? StInit : StCompare;
                    w_status_next = StatOk;
                    w_pcnt_next   = '0;
                end
            end
            StInit: begin
                w_state_next = StSettle;
            end
            StCompare: begin
                if (w_in_tol) begin
                    w_state_next  = StDone;
                    w_status_next = StatOk;
                end else if (w_budget_out) begin
                    w_state_next  = StDone;
                    w_status_next = StatTimeout;
                end else begin
                    w_state_next = StPulse;
                    w_pcnt_next  = r_pulse_cnt + 8'd1;
                end
            end
            StPulse: begin
                w_state_next = StSettle;
            end
            StSettle: begin
                if (r_settle_cnt == SETTLE_LAST) begin
                    w_state_next = StCompare;
                end else begin
                    w_settle_next = r_settle_cnt + 4'd1;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
        // Abort overrides every transition, including a pulse about to be issued.
        if (w_abort) begin
            w_state_next  = StDone;
            w_status_next = StatAbort;
            w_pcnt_next   = r_pulse_cnt;
            w_settle_next = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_target     <= '0;
            r_settle_cnt <= '0;
            r_status     <= StatOk;
            r_pulse_cnt  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_settle_cnt <= w_settle_next;
            r_status     <= w_status_next;
            r_pulse_cnt  <= w_pcnt_next;
            if (w_accept) begin
                r_target <= i_target_g;
            end
        end
    end

    // Cell-facing outputs are registered from the next state so they align with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vin       <= '0;
            r_v_valid   <= 1'b0;
            r_mem_reset <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_vin       <= (w_state_next == StPulse) ? w_pulse_v : '0;
            r_v_valid   <= (w_state_next == StPulse) || (w_state_next == StInit);
            r_mem_reset <= (w_state_next == StInit);
            r_busy      <= (w_state_next != StIdle);
            r_done      <= (w_state_next == StDone);
        end
    end

    assign o_vin       = r_vin;
    assign o_v_valid   = r_v_valid;
    assign o_mem_reset = r_mem_reset;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_status    = r_status;
    assign o_pulse_cnt = r_pulse_cnt;

endmodule

// File: tb/tb_mem_prog_ctrl.sv
// Bench for mem_prog_ctrl: two controllers each drive a simple memristor cell; a trace
// model predicts every output cycle of controller A, directed literals pin both.
module tb_mem_prog_ctrl;

    localparam int SETTLE = 1;
    localparam int TOLM   = 4;
    localparam int THR    = 64;
    localparam int VHI    = 32;
    localparam int VLO    = 8;
    localparam int VTH    = 8;
    localparam int GINIT  = 100;
    localparam int MAXP_A = 255;

    typedef struct packed {
        logic [15:0] vin;
        logic        vv;
        logic        mr;
        logic        busy;
        logic        done;
        logic [1:0]  st;
        logic [7:0]  pc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               start_a, init_a, abort_a;
    logic signed [15:0] tgt_a;
    logic signed [15:0] vin_a;
    logic               vv_a, mr_a, busy_a, done_a;
    logic [1:0]         st_a;
    logic [7:0]         pc_a;
    logic               start_b, init_b, abort_b;
    logic signed [15:0] tgt_b;
    logic signed [15:0] vin_b;
    logic               vv_b, mr_b, busy_b, done_b;
    logic [1:0]         st_b;
    logic [7:0]         pc_b;

    logic signed [15:0] g_a = 16'sd100;
    logic signed [15:0] g_b = 16'sd100;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];
    exp_t idle_exp;
    int   model_g = GINIT;
    int   vlog_a[$];
    int   vlog_b[$];
    int   nmr_a = 0;

    mem_prog_ctrl u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_init(init_a), .i_abort(abort_a),
        .i_target_g(tgt_a), .i_g(g_a), .o_vin(vin_a), .o_v_valid(vv_a), .o_mem_reset(mr_a),
        .o_busy(busy_a), .o_done(done_a), .o_status(st_a), .o_pulse_cnt(pc_a)
    );

    mem_prog_ctrl #(.MAX_PULSES(3)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_init(init_b), .i_abort(abort_b),
        .i_target_g(tgt_b), .i_g(g_b), .o_vin(vin_b), .o_v_valid(vv_b), .o_mem_reset(mr_b),
        .o_busy(busy_b), .o_done(done_b), .o_status(st_b), .o_pulse_cnt(pc_b)
    );

    // Cell: c=1, N_EXP=1, Vth=8 -> dG = Vin when |Vin| >= Vth; mem_reset restores Ginit.
    always @(posedge clk) begin
        if (vv_a) g_a <= mr_a ? 16'sd100 : ((vin_a >= VTH || vin_a <= -VTH) ? g_a + vin_a : g_a);
        if (vv_b) g_b <= mr_b ? 16'sd100 : ((vin_b >= VTH || vin_b <= -VTH) ? g_b + vin_b : g_b);
    end

    function automatic exp_t mk(int vin, bit vv, bit mr, bit busy, bit done, int st, int pc);
        exp_t e;
        e.vin = 16'(vin); e.vv = vv; e.mr = mr; e.busy = busy; e.done = done;
        e.st = 2'(st); e.pc = 8'(pc);
        return e;
    endfunction

    function automatic int iabs(int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic check(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    // Expected output trace of a whole operation, from the programming rules alone.
    task automatic plan(input int t, input bit ini);
        int g, p, err, v, res;
        bit fin;
        g = model_g; p = 0; res = 0; fin = 0;
        if (ini) begin
            q.push_back(mk(0, 1, 1, 1, 0, 0, 0));
            g = GINIT;
            repeat (SETTLE) q.push_back(mk(0, 0, 0, 1, 0, 0, 0));
        end
        for (int it = 0; it < 300 && !fin; it++) begin
            q.push_back(mk(0, 0, 0, 1, 0, 0, p));
            err = t - g;
            if (iabs(err) <= TOLM) begin
                res = 0; fin = 1;
            end else if (p == MAXP_A) begin
                res = 1; fin = 1;
            end else begin
                v = (iabs(err) > THR) ? VHI : VLO;
                if (err < 0) v = -v;
                p++;
                q.push_back(mk(v, 1, 0, 1, 0, 0, p));
                if (iabs(v) >= VTH) g += v;
                repeat (SETTLE) q.push_back(mk(0, 0, 0, 1, 0, 0, p));
            end
        end
        q.push_back(mk(0, 0, 0, 1, 1, res, p));
        idle_exp = mk(0, 0, 0, 0, 0, res, p);
    endtask

    task automatic compare_loop();
        exp_t cur, act;
        int   cyc, sv;
        cyc = 0;
        idle_exp = '0;
        forever begin
            @(negedge clk);
            cyc++;
            act = mk(int'(vin_a), vv_a, mr_a, busy_a, done_a, int'(st_a), int'(pc_a));
            if (!rst_n) begin
                q.delete();
                idle_exp = '0;
                cur = '0;
            end else if (q.size() > 0) begin
                cur = q.pop_front();
            end else begin
                cur = idle_exp;
            end
            n_checks++;
            if (act !== cur) begin
                n_errors++;
                $display("FAIL model cycle %0d: got vin=%0d vv=%b mr=%b busy=%b done=%b st=%b pc=%0d, expected vin=%0d vv=%b mr=%b busy=%b done=%b st=%b pc=%0d",
                         cyc, $signed(act.vin), act.vv, act.mr, act.busy, act.done, act.st, act.pc,
                         $signed(cur.vin), cur.vv, cur.mr, cur.busy, cur.done, cur.st, cur.pc);
            end
            if (rst_n) begin
                sv = int'($signed(cur.vin));
                if (cur.vv) model_g = cur.mr ? GINIT : ((iabs(sv) >= VTH) ? model_g + sv : model_g);
                if (cur.busy && !cur.done && abort_a) begin
                    q.delete();
                    q.push_back(mk(0, 0, 0, 1, 1, 2, int'(cur.pc)));
                    idle_exp = mk(0, 0, 0, 0, 0, 2, int'(cur.pc));
                end else if (!cur.busy && start_a) begin
                    plan(int'(tgt_a), init_a);
                end
            end
        end
    endtask

    task automatic record_loop();
        forever begin
            @(negedge clk);
            if (rst_n && vv_a && !mr_a) vlog_a.push_back(int'(vin_a));
            if (rst_n && mr_a) nmr_a++;
            if (rst_n && vv_b && !mr_b) vlog_b.push_back(int'(vin_b));
        end
    endtask

    task automatic run_a(input int t, input bit ini);
        bit seen;
        seen = 0;
        start_a = 1; init_a = ini; tgt_a = 16'(t);
        @(posedge clk); #1;
        start_a = 0; init_a = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (done_a) seen = 1;
            else begin @(posedge clk); #1; end
        end
        check($sformatf("run_a_done_seen_t%0d", t), int'(seen), 1);
        @(posedge clk); #1;
    endtask

    task automatic pulse_abort_idle();
        abort_a = 1;
        @(posedge clk); #1;
        abort_a = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        int base, mr0, nb, nd;
        bit seen;
        int exp200[6];
        exp200 = '{32, 32, 8, 8, 8, 8};
        rst_n = 0;
        start_a = 0; init_a = 0; abort_a = 0; tgt_a = '0;
        start_b = 0; init_b = 0; abort_b = 0; tgt_b = '0;
        fork
            compare_loop();
            record_loop();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(busy_a), 0);
        check("reset_vv", int'(vv_a), 0);
        check("reset_status", int'(st_a), 0);
        check("reset_pcnt_b", int'(pc_b), 0);
        rst_n = 1;
        @(posedge clk); #1;

        // target == G: zero pulses, done in k+2; abort with start in IDLE loses to start.
        base = vlog_a.size();
        start_a = 1; init_a = 0; tgt_a = 16'sd100; abort_a = 1;
        @(posedge clk); #1;
        start_a = 0; abort_a = 0;
        check("t100_k1_busy", int'(busy_a), 1);
        check("t100_k1_done", int'(done_a), 0);
        @(posedge clk); #1;
        check("t100_k2_done", int'(done_a), 1);
        check("t100_status", int'(st_a), 0);
        @(posedge clk); #1;
        check("t100_idle_busy", int'(busy_a), 0);
        check("t100_npulse", vlog_a.size() - base, 0);
        check("t100_pcnt", int'(pc_a), 0);

        // Coarse then fine approach from below.
        base = vlog_a.size();
        run_a(200, 0);
        check("t200_g", int'(g_a), 196);
        check("t200_status", int'(st_a), 0);
        check("t200_pcnt", int'(pc_a), 6);
        check("t200_npulse", vlog_a.size() - base, 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t200_vin%0d", i), (base + i < vlog_a.size()) ? vlog_a[base + i] : 0,
                  exp200[i]);

        // Re-init to Ginit, then fine pulses downward.
        base = vlog_a.size();
        mr0 = nmr_a;
        run_a(40, 1);
        check("t40_mem_reset_cnt", nmr_a - mr0, 1);
        check("t40_npulse", vlog_a.size() - base, 7);
        for (int i = 0; i < 7; i++)
            check($sformatf("t40_vin%0d", i), (base + i < vlog_a.size()) ? vlog_a[base + i] : 0, -8);
        check("t40_g", int'(g_a), 44);
        check("t40_pcnt", int'(pc_a), 7);
        check("t40_status", int'(st_a), 0);

        pulse_abort_idle();
        check("idle_abort_status", int'(st_a), 0);
        check("idle_abort_busy", int'(busy_a), 0);

        // Abort in the settle after the second pulse.
        base = vlog_a.size();
        start_a = 1; init_a = 1; tgt_a = 16'sd200;
        @(posedge clk); #1;
        start_a = 0; init_a = 0;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (pc_a == 8'd2) seen = 1;
            else begin @(posedge clk); #1; end
        end
        check("abort_reached_pulse2", int'(seen), 1);
        @(posedge clk); #1;
        check("abort_settle_vv", int'(vv_a), 0);
        abort_a = 1;
        @(posedge clk); #1;
        abort_a = 0;
        check("abort_done", int'(done_a), 1);
        check("abort_status", int'(st_a), 2);
        check("abort_vv", int'(vv_a), 0);
        @(posedge clk); #1;
        check("abort_idle_busy", int'(busy_a), 0);
        check("abort_npulse", vlog_a.size() - base, 2);
        check("abort_g", int'(g_a), 164);
        check("abort_pcnt", int'(pc_a), 2);

        // Reset during a pulse cycle kills the in-flight strobe.
        start_a = 1; init_a = 0; tgt_a = 16'sd200;
        @(posedge clk); #1;
        start_a = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (vv_a) seen = 1;
            else begin @(posedge clk); #1; end
        end
        check("rst_reached_pulse", int'(seen), 1);
        #1 rst_n = 0;
        #1;
        check("rst_vv", int'(vv_a), 0);
        check("rst_vin", int'(vin_a), 0);
        check("rst_busy", int'(busy_a), 0);
        @(posedge clk); #1;
        rst_n = 1;
        check("rst_g_unchanged", int'(g_a), 164);
        @(posedge clk); #1;
        run_a(180, 0);
        check("post_rst_g", int'(g_a), 180);
        check("post_rst_pcnt", int'(pc_a), 2);
        check("post_rst_status", int'(st_a), 0);

        // Pulse budget of 3 on controller B.
        base = vlog_b.size();
        start_b = 1; tgt_b = 16'sd1000;
        @(posedge clk); #1;
        start_b = 0;
        nb = 0; nd = 0;
        for (int i = 0; i < 40 && busy_b; i++) begin
            nb++;
            if (done_b) nd++;
            @(posedge clk); #1;
        end
        check("tmo_busy_cycles", nb, 11);
        check("tmo_done_cnt", nd, 1);
        check("tmo_status", int'(st_b), 1);
        check("tmo_pcnt", int'(pc_b), 3);
        check("tmo_g", int'(g_b), 196);
        check("tmo_npulse", vlog_b.size() - base, 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("tmo_vin%0d", i), (base + i < vlog_b.size()) ? vlog_b[base + i] : 0, 32);

        repeat (2) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_prog_ctrl.md
Name: mem_prog_ctrl

Overview:
- Write-verify programming controller that drives one memristor cell model.
- Controller is the stimulus side: it generates Vin/V_valid/reset for the cell and reads back the cell's conductance G.
- It applies SET or RESET pulses, coarse or fine, until G lands within a tolerance of a requested target, or until a pulse budget runs out.
- Sits between the training/quantization weight loader and each memristor cell instance.

Parameters:
- M, 15: cell voltage MSB index; Vin is M+1 bits signed.
- N, 15: conductance MSB index; G and target are N+1 bits signed.
- V_HI, 32: coarse pulse magnitude. Must be at least the cell Vth.
- V_LO, 8: fine pulse magnitude. Must be at least the cell Vth.
- COARSE_THR, 64: |err| above this uses V_HI, otherwise V_LO.
- TOL, 4: done when |err| <= TOL.
- MAX_PULSES, 255: pulse budget per operation, 1..255.
- SETTLE_CYC, 1: wait cycles after each pulse before compare, 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- start  input  1  begin operation; sampled only in IDLE.
- init  input  1  sampled with start; 1 = reset cell to Ginit before programming.
- abort  input  1  synchronous abort of a running operation.
- target_G  input  N+1  signed target conductance; latched on accepted start.
- G  input  N+1  signed conductance read back from the cell.
- Vin  output  M+1  signed pulse voltage to the cell.
- V_valid  output  1  cell update strobe.
- mem_reset  output  1  cell re-init strobe.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.
- status  output  2  result code: 00 OK, 01 TIMEOUT, 10 ABORT. Held until the next accepted start.
- pulse_cnt  output  8  pulses applied in the current or last operation.

Behaviour:
- Reset (rst low, async): state=IDLE; Vin=0, V_valid=0, mem_reset=0, busy=0, done=0, status=00, pulse_cnt=0, settle counter=0.
- All outputs are registered. Vin is 0 in every state except PULSE.
- IDLE:
  - On start=1, latch target_G, clear pulse_cnt, clear status.
  - Go to INIT if init=1, else go to COMPARE.
  - start while busy is ignored.
- INIT (1 cycle): V_valid=1, mem_reset=1, Vin=0. Then go to SETTLE.
- COMPARE (1 cycle): err = target - G, computed at N+2 bits signed with no overflow. In priority order:
  - If |err| <= TOL: go to DONE, status=00.
  - Else if pulse_cnt == MAX_PULSES: go to DONE, status=01.
  - Else go to PULSE.
- PULSE (1 cycle):
  - V_valid=1, mem_reset=0.
  - Vin = +mag if err > 0, -mag if err < 0.
  - mag = V_HI if |err| > COARSE_THR, else V_LO.
  - pulse_cnt increments on entry to PULSE.
  - Then go to SETTLE.
- SETTLE: hold for SETTLE_CYC cycles with V_valid=0 and Vin=0, then go to COMPARE. G is sampled only in COMPARE.
- DONE (1 cycle): done=1. Next state is IDLE with busy=0.
- Latency:
  - Start accepted at edge k puts the FSM in COMPARE at cycle k+1.
  - Each pulse iteration costs 2+SETTLE_CYC cycles.
  - With a zero-pulse completion, done is high in cycle k+2.
- Abort:
  - In any busy state other than DONE, abort=1 at an edge sends the FSM to DONE with status=10.
  - Vin and V_valid are forced to 0 from that edge, so no pulse is issued in the following cycle.
  - abort has priority over every other transition.
  - abort in IDLE or DONE is ignored.
- start and abort asserted together in IDLE: start wins.
- rst asserted mid-operation: all outputs clear immediately, including a V_valid that was in flight.

Test Plan:
(Cell configured c=1, N_EXP=1, Vth=8, Ginit=100, defaults otherwise.)
- target_G=100, init=0 -> no V_valid; done in cycle k+2; status=00; pulse_cnt=0.
- target_G=200 -> Vin sequence +32,+32,+8,+8,+8,+8; G=196; status=00; pulse_cnt=6.
- After G=196: target_G=40, init=1 -> one mem_reset strobe (G=100), then seven Vin=-8 pulses; G=44; status=00; pulse_cnt=7.
- MAX_PULSES=3, target_G=1000 -> three +32 pulses; G=196; status=01; pulse_cnt=3; done pulses once.
- Abort during the SETTLE after pulse 2 of the target_G=200 case -> no further V_valid; G=164; status=10; done asserted the next cycle.
- rst low during the PULSE cycle -> V_valid, Vin and busy read 0 before the next edge; a later start runs normally.
